// File: rtl/sdu_pkg.sv
// Shared encodings for the serial debug unit run/step sequencer:
// command opcodes, stop causes and sequencer states.
package sdu_pkg;

    typedef enum logic [1:0] {
        OP_STEP    = 2'b00,
        OP_RUN     = 2'b01,
        OP_RUN_BP  = 2'b10,
        OP_CLR_CNT = 2'b11
    } sdu_op_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_COUNT = 3'd1,
        CAUSE_HALT  = 3'd2,
        CAUSE_BP    = 3'd3,
        CAUSE_WDOG  = 3'd4
    } sdu_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH_HI,
        ST_PH_LO,
        ST_FIN
    } sdu_state_e;

endpackage

// File: rtl/sdu_clk_pulse.sv
// Phase timer: a start strobe launches one CPU clock pulse, HI_CYC cycles
// high then LO_CYC cycles low, with strobes on the last cycle of each phase.
module sdu_clk_pulse #(
    parameter int HI_CYC = 2,
    parameter int LO_CYC = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic clk_cpu,
    output logic last_hi,
    output logic last_lo
);

    localparam int MAX_CYC = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] HI_LAST = TMR_W'(HI_CYC - 1);
    localparam logic [TMR_W-1:0] LO_LAST = TMR_W'(LO_CYC - 1);

    logic             hi_q;
    logic             lo_q;
    logic [TMR_W-1:0] tmr_q;

    assign clk_cpu = hi_q;
    assign last_hi = hi_q && (tmr_q == HI_LAST);
    assign last_lo = lo_q && (tmr_q == LO_LAST);

    // A start on the last low cycle chains straight into the next pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
            tmr_q <= '0;
        end else if (start) begin
            hi_q  <= 1'b1;
            lo_q  <= 1'b0;
            tmr_q <= '0;
        end else if (hi_q) begin
            if (last_hi) begin
                hi_q  <= 1'b0;
                lo_q  <= 1'b1;
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end
        end else if (lo_q) begin
            if (last_lo) begin
                lo_q  <= 1'b0;
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdu_run_ctrl.sv
// CPU run/step sequencer: step, free-run and run-to-breakpoint over a gated
// CPU clock. Optional watchdog stop enabled by defining SDU_RUN_WDOG_EN.
module sdu_run_ctrl
    import sdu_pkg::*;
#(
    parameter int HI_CYC   = 2,
    parameter int LO_CYC   = 2,
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [31:0]      bp_addr,
    input  logic             halt_req,
    input  logic             pc_chk,
    input  logic [31:0]      npc,
    output logic             clk_cpu,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stop_cause,
    output logic [31:0]      cyc_total
);

    sdu_state_e       state_q, state_d;
    sdu_op_e          op_q;
    sdu_cause_e       cause_q, cause_d;
    logic [CNT_W-1:0] rem_q;
    logic [31:0]      bp_q;
    logic [31:0]      cyc_total_q;
    logic             accept, start, clr_total;
    logic             last_hi, last_lo;
    logic             bp_hit, count_hit, wdog_hit;

    sdu_clk_pulse #(
        .HI_CYC (HI_CYC),
        .LO_CYC (LO_CYC)
    ) u_pulse (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .clk_cpu (clk_cpu),
        .last_hi (last_hi),
        .last_lo (last_lo)
    );

    assign accept    = (state_q == ST_IDLE) && cmd_vld;
    assign clr_total = accept && (cmd_op == OP_CLR_CNT);
    assign bp_hit    = (op_q == OP_RUN_BP) && pc_chk && (npc == bp_q);
    assign count_hit = (op_q == OP_STEP) && (rem_q == '0);

`ifdef SDU_RUN_WDOG_EN
    logic [31:0] wdog_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_cnt_q <= '0;
        end else if (accept) begin
            wdog_cnt_q <= {31'd0, start};
        end else if (start) begin
            wdog_cnt_q <= wdog_cnt_q + 32'd1;
        end
    end

    assign wdog_hit = ((op_q == OP_RUN) || (op_q == OP_RUN_BP)) &&
                      (wdog_cnt_q >= 32'(WDOG_CYC));
`else
    logic unused_wdog;
    assign unused_wdog = ^32'(WDOG_CYC);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cause_d = CAUSE_NONE;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    if (cmd_op == OP_CLR_CNT) begin
                        state_d = ST_FIN;
                    end else if ((cmd_op == OP_STEP) && (cmd_cnt == '0)) begin
                        state_d = ST_FIN;
                        cause_d = CAUSE_COUNT;
                    end else begin
                        state_d = ST_PH_HI;
                        start   = 1'b1;
                    end
                end
            end
            ST_PH_HI: begin
                if (last_hi) state_d = ST_PH_LO;
            end
            ST_PH_LO: begin
                // Stop checks only at the end of a full pulse; priority bp > halt > wdog > count.
                if (last_lo) begin
                    state_d = ST_FIN;
                    if (bp_hit)         cause_d = CAUSE_BP;
                    else if (halt_req)  cause_d = CAUSE_HALT;
                    else if (wdog_hit)  cause_d = CAUSE_WDOG;
                    else if (count_hit) cause_d = CAUSE_COUNT;
                    else begin
                        state_d = ST_PH_HI;
                        start   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_STEP;
            cause_q     <= CAUSE_NONE;
            rem_q       <= '0;
            cyc_total_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= sdu_op_e'(cmd_op);
                cause_q <= CAUSE_NONE;
            end
            if (state_d == ST_FIN) cause_q <= cause_d;
            if (clr_total)  cyc_total_q <= '0;
            else if (start) cyc_total_q <= cyc_total_q + 32'd1;
            // The first pulse is launched on the accept edge, so it consumes a step there.
            if (accept)                         rem_q <= start ? cmd_cnt - 1'b1 : cmd_cnt;
            else if (start && op_q == OP_STEP)  rem_q <= rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) bp_q <= bp_addr;
    end

    assign cmd_rdy    = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign stop_cause = cause_q;
    assign cyc_total  = cyc_total_q;

endmodule

// File: tb/tb_sdu_run_ctrl.sv
// Directed bench for sdu_run_ctrl with HI_CYC=LO_CYC=2; the watchdog case
// is compiled only when SDU_RUN_WDOG_EN is defined (WDOG_CYC=8).
module tb_sdu_run_ctrl;

    localparam int HI = 2;
    localparam int LO = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_cnt = 16'd0;
    logic [31:0] bp_addr = 32'd0;
    logic        halt_req = 1'b0;
    logic        pc_chk = 1'b0;
    logic [31:0] npc = 32'd0;
    logic        clk_cpu;
    logic        busy;
    logic        done;
    logic [2:0]  stop_cause;
    logic [31:0] cyc_total;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;

    sdu_run_ctrl #(
        .HI_CYC   (HI),
        .LO_CYC   (LO),
        .CNT_W    (16),
        .WDOG_CYC (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .bp_addr    (bp_addr),
        .halt_req   (halt_req),
        .pc_chk     (pc_chk),
        .npc        (npc),
        .clk_cpu    (clk_cpu),
        .busy       (busy),
        .done       (done),
        .stop_cause (stop_cause),
        .cyc_total  (cyc_total)
    );

    always #5 clk = ~clk;

    // Presents one command for the accept edge; returns #1 after that edge.
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] cnt, input logic [31:0] bp);
        cmd_vld = 1'b1;
        cmd_op  = op;
        cmd_cnt = cnt;
        bp_addr = bp;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    // Cycle numbering: accept cycle is 1. Also models the CPU (npc += 4 per rising edge).
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] cnt, input logic [31:0] bp,
                           input int halt_pulse, output int cycles, output int pulses,
                           output int bad_wave, output int bad_ctrl);
        int n;
        logic prev;
        pulses = 0; bad_wave = 0; bad_ctrl = 0; cycles = -1;
        send_cmd(op, cnt, bp);
        n = 2; prev = 1'b0;
        while (n <= 4000) begin
            if (done === 1'b1) begin
                cycles = n;
                if (clk_cpu !== 1'b0) bad_wave++;
                if (busy !== 1'b1 || cmd_rdy !== 1'b0) bad_ctrl++;
                break;
            end
            if (clk_cpu === 1'b1 && !prev) begin
                pulses++;
                npc = npc + 32'd4;
            end
            if (halt_pulse != 0 && pulses == halt_pulse && clk_cpu === 1'b1) halt_req = 1'b1;
            if (clk_cpu !== ((((n - 2) % (HI + LO)) < HI) ? 1'b1 : 1'b0)) bad_wave++;
            if (busy !== 1'b1 || cmd_rdy !== 1'b0) bad_ctrl++;
            prev = clk_cpu;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (clk_cpu !== 1'b0) begin errors++; $display("FAIL reset_clk_cpu: got %0b expected 0", clk_cpu); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %0b expected 1", cmd_rdy); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b/%0b expected 0/0", busy, done); end
        checks++; if (stop_cause !== 3'd0 || cyc_total !== 32'd0) begin errors++; $display("FAIL reset_cause_total: got %0d/%0d expected 0/0", stop_cause, cyc_total); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got rdy=%0b busy=%0b expected 1/0", cmd_rdy, busy); end
    endtask

    task automatic test_step3();
        int cyc, pul, bw, bc;
        run_cmd(2'b00, 16'd3, 32'd0, 0, cyc, pul, bw, bc);
        exp_total += 3;
        checks++; if (cyc != 14) begin errors++; $display("FAIL step3_done_cycle: got %0d expected 14", cyc); end
        checks++; if (pul != 3) begin errors++; $display("FAIL step3_pulses: got %0d expected 3", pul); end
        checks++; if (bw != 0) begin errors++; $display("FAIL step3_waveform: got %0d bad cycles expected 0", bw); end
        checks++; if (bc != 0) begin errors++; $display("FAIL step3_busy_rdy: got %0d bad cycles expected 0", bc); end
        checks++; if (stop_cause !== 3'd1) begin errors++; $display("FAIL step3_cause: got %0d expected 1", stop_cause); end
        checks++; if (cyc_total !== 32'(exp_total)) begin errors++; $display("FAIL step3_total: got %0d expected %0d", cyc_total, exp_total); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL step3_after_fin: got done=%0b busy=%0b rdy=%0b expected 0/0/1", done, busy, cmd_rdy); end
        checks++; if (stop_cause !== 3'd1) begin errors++; $display("FAIL step3_cause_held: got %0d expected 1", stop_cause); end
    endtask

    task automatic test_step0();
        int cyc, pul, bw, bc;
        run_cmd(2'b00, 16'd0, 32'd0, 0, cyc, pul, bw, bc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL step0_done_cycle: got %0d expected 2", cyc); end
        checks++; if (pul != 0 || bw != 0) begin errors++; $display("FAIL step0_no_pulse: got %0d pulses %0d bad expected 0/0", pul, bw); end
        checks++; if (stop_cause !== 3'd1) begin errors++; $display("FAIL step0_cause: got %0d expected 1", stop_cause); end
        checks++; if (cyc_total !== 32'(exp_total)) begin errors++; $display("FAIL step0_total: got %0d expected %0d", cyc_total, exp_total); end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_cnt();
        int cyc, pul, bw, bc;
        run_cmd(2'b11, 16'd5, 32'd0, 0, cyc, pul, bw, bc);
        exp_total = 0;
        checks++; if (cyc != 2 || pul != 0) begin errors++; $display("FAIL clr_timing: got cycle %0d pulses %0d expected 2/0", cyc, pul); end
        checks++; if (stop_cause !== 3'd0) begin errors++; $display("FAIL clr_cause: got %0d expected 0", stop_cause); end
        checks++; if (cyc_total !== 32'd0) begin errors++; $display("FAIL clr_total: got %0d expected 0", cyc_total); end
        @(posedge clk); #1;
    endtask

    task automatic test_run_bp();
        int cyc, pul, bw, bc;
        npc = 32'd0; pc_chk = 1'b1;
        run_cmd(2'b10, 16'd1, 32'h0000_0010, 0, cyc, pul, bw, bc);
        exp_total += 4;
        checks++; if (pul != 4 || cyc != 18) begin errors++; $display("FAIL bp_pulses: got %0d pulses cycle %0d expected 4/18", pul, cyc); end
        checks++; if (stop_cause !== 3'd3) begin errors++; $display("FAIL bp_cause: got %0d expected 3", stop_cause); end
        checks++; if (bw != 0 || bc != 0) begin errors++; $display("FAIL bp_wave_ctrl: got %0d/%0d bad expected 0/0", bw, bc); end
        checks++; if (cyc_total !== 32'(exp_total)) begin errors++; $display("FAIL bp_total: got %0d expected %0d", cyc_total, exp_total); end
        @(posedge clk); #1;
    endtask

    task automatic test_run_halt();
        int cyc, pul, bw, bc;
        pc_chk = 1'b0;
        run_cmd(2'b01, 16'd0, 32'd0, 5, cyc, pul, bw, bc);
        halt_req = 1'b0;
        exp_total += 5;
        checks++; if (pul != 5 || cyc != 22) begin errors++; $display("FAIL halt_pulses: got %0d pulses cycle %0d expected 5/22", pul, cyc); end
        checks++; if (bw != 0) begin errors++; $display("FAIL halt_full_width: got %0d bad cycles expected 0", bw); end
        checks++; if (stop_cause !== 3'd2) begin errors++; $display("FAIL halt_cause: got %0d expected 2", stop_cause); end
        checks++; if (cyc_total !== 32'(exp_total)) begin errors++; $display("FAIL halt_total: got %0d expected %0d", cyc_total, exp_total); end
        @(posedge clk); #1;
    endtask

    task automatic test_bp_halt_coincide();
        int cyc, pul, bw, bc;
        npc = 32'd0; pc_chk = 1'b1;
        run_cmd(2'b10, 16'd0, 32'h0000_0010, 4, cyc, pul, bw, bc);
        halt_req = 1'b0;
        exp_total += 4;
        checks++; if (pul != 4) begin errors++; $display("FAIL coincide_pulses: got %0d expected 4", pul); end
        checks++; if (stop_cause !== 3'd3) begin errors++; $display("FAIL coincide_cause: got %0d expected 3", stop_cause); end
        @(posedge clk); #1;
    endtask

    task automatic test_halt_at_accept();
        int cyc, pul, bw, bc;
        halt_req = 1'b1;
        run_cmd(2'b01, 16'd0, 32'd0, 0, cyc, pul, bw, bc);
        halt_req = 1'b0;
        exp_total += 1;
        checks++; if (pul != 1 || cyc != 6) begin errors++; $display("FAIL halt_accept_pulses: got %0d pulses cycle %0d expected 1/6", pul, cyc); end
        checks++; if (stop_cause !== 3'd2) begin errors++; $display("FAIL halt_accept_cause: got %0d expected 2", stop_cause); end
        @(posedge clk); #1;
    endtask

    task automatic test_bp_resume();
        int cyc, pul, bw, bc;
        npc = 32'h0000_0010; pc_chk = 1'b1;
        run_cmd(2'b10, 16'd0, 32'h0000_0010, 2, cyc, pul, bw, bc);
        halt_req = 1'b0;
        exp_total += 2;
        checks++; if (pul != 2) begin errors++; $display("FAIL bp_resume_pulses: got %0d expected 2", pul); end
        checks++; if (stop_cause !== 3'd2) begin errors++; $display("FAIL bp_resume_cause: got %0d expected 2", stop_cause); end
        checks++; if (cyc_total !== 32'(exp_total)) begin errors++; $display("FAIL bp_resume_total: got %0d expected %0d", cyc_total, exp_total); end
        pc_chk = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef SDU_RUN_WDOG_EN
    task automatic test_wdog();
        int cyc, pul, bw, bc;
        run_cmd(2'b01, 16'd0, 32'd0, 0, cyc, pul, bw, bc);
        exp_total += 8;
        checks++; if (pul != 8 || cyc != 34) begin errors++; $display("FAIL wdog_pulses: got %0d pulses cycle %0d expected 8/34", pul, cyc); end
        checks++; if (stop_cause !== 3'd4) begin errors++; $display("FAIL wdog_cause: got %0d expected 4", stop_cause); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_pulse();
        int n;
        int cyc, pul, bw, bc;
        send_cmd(2'b01, 16'd0, 32'd0);
        n = 0;
        while (clk_cpu !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (clk_cpu !== 1'b1) begin errors++; $display("FAIL rstmid_reach_hi: got %0b expected 1", clk_cpu); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (clk_cpu !== 1'b0) begin errors++; $display("FAIL rstmid_clk_cpu: got %0b expected 0", clk_cpu); end
        checks++; if (busy !== 1'b0 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_rdy: got %0b/%0b expected 0/1", busy, cmd_rdy); end
        checks++; if (cyc_total !== 32'd0) begin errors++; $display("FAIL rstmid_total: got %0d expected 0", cyc_total); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        run_cmd(2'b00, 16'd1, 32'd0, 0, cyc, pul, bw, bc);
        checks++; if (pul != 1 || cyc != 6 || cyc_total !== 32'd1) begin errors++; $display("FAIL rstmid_recover: got %0d pulses cycle %0d total %0d expected 1/6/1", pul, cyc, cyc_total); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_step3();
        test_step0();
        test_clr_cnt();
        test_run_bp();
        test_run_halt();
        test_bp_halt_coincide();
        test_halt_at_accept();
        test_bp_resume();
`ifdef SDU_RUN_WDOG_EN
        test_wdog();
`endif
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdu_run_ctrl.md
Name: sdu_run_ctrl

Overview:
- CPU run/step sequencer for the serial debug unit.
- Accepts run commands from the debug command processor and generates the gated `clk_cpu` pulse train.
- Supports single/multi-step, free-run, and run-to-breakpoint (compares CPU `npc` against a breakpoint address).
- Reports completion and stop cause back to the command processor, which formats the UART reply.

Parameters:
- HI_CYC, 2, clk cycles `clk_cpu` is held high per CPU cycle (>=1)
- LO_CYC, 2, clk cycles `clk_cpu` is held low per CPU cycle (>=1)
- CNT_W, 16, width of step count
- WDOG_CYC, 1000000, CPU-cycle limit for watchdog (only with optional feature)

Ports:
- clk  in  1  debug-unit clock
- rstn  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_op  in  2  00 STEP, 01 RUN, 10 RUN_BP, 11 CLR_CNT
- cmd_cnt  in  CNT_W  step count (STEP only)
- bp_addr  in  32  breakpoint address, sampled at command accept
- halt_req  in  1  level halt request from command processor
- pc_chk  in  1  CPU asserts when npc is valid for breakpoint compare
- npc  in  32  CPU next PC
- clk_cpu  out  1  gated CPU clock
- busy  out  1  high while a command executes
- done  out  1  one-cycle pulse at command completion
- stop_cause  out  3  0 none, 1 count, 2 halt, 3 breakpoint, 4 watchdog
- cyc_total  out  32  total CPU rising edges issued

Behaviour:
- Clocking: one clock `clk`; reset `rstn` asynchronous active-low.
- Reset values: `clk_cpu`=0, `cmd_rdy`=1, `busy`=0, `done`=0, `stop_cause`=0, `cyc_total`=0; state IDLE.
- Reset mid-pulse: `clk_cpu` drops immediately; no cycle completes.
- States: IDLE, PH_HI, PH_LO, FIN.
- IDLE:
  - `cmd_rdy`=1.
  - Accept on `cmd_vld&&cmd_rdy`; latch op, cnt, bp_addr.
  - `cmd_rdy`=0 in all other states.
- CLR_CNT: zero `cyc_total`; go to FIN with cause 0. No pulse.
- STEP with cnt=0: go to FIN with cause 1. No pulse.
- STEP/RUN/RUN_BP otherwise: go to PH_HI the cycle after accept.
- PH_HI:
  - `clk_cpu`=1 for exactly HI_CYC clk cycles.
  - `cyc_total` increments on PH_HI entry; wraps 0xFFFFFFFF→0.
  - Remaining-step counter decrements on PH_HI entry (STEP only).
- PH_LO:
  - `clk_cpu`=0 for exactly LO_CYC clk cycles.
  - On the last PH_LO cycle, evaluate stop conditions:
    - bp: op=RUN_BP && `pc_chk` && `npc`==latched bp_addr.
    - halt: `halt_req`.
    - count: op=STEP && remaining=0.
  - Any condition true → FIN with cause by priority bp > halt > count. Otherwise → PH_HI.
- A started pulse always completes fully; `halt_req` never truncates `clk_cpu`.
- No breakpoint check before the first pulse, so resuming from a breakpoint PC advances.
- Per CPU cycle: HI_CYC+LO_CYC clk cycles.
- FIN:
  - One cycle; `done`=1; `stop_cause` registered and held until the next accept.
  - Then IDLE.
- `busy`=1 from the cycle after accept through FIN inclusive.
- `halt_req` in IDLE: ignored. `halt_req` held at accept: stops after exactly one CPU cycle.
- RUN ignores `pc_chk`/`npc`; RUN_BP ignores cnt.

Optional Feature:
- SDU_RUN_WDOG_EN defined:
  - Per-command CPU-cycle counter; RUN/RUN_BP reaching WDOG_CYC cycles stops at end of PH_LO with cause 4.
  - Priority bp > halt > wdog.
- Undefined: no watchdog counter; cause 4 never produced; WDOG_CYC unused.

Decomposition:
- Package `sdu_pkg`: op encodings (STEP, RUN, RUN_BP, CLR_CNT), stop-cause encodings, state enum.
- Sub-module `sdu_clk_pulse`: phase timer producing one HI_CYC/LO_CYC pulse on start, with `last_lo` strobe. Used by `sdu_run_ctrl` for the pulse timing.

Test Plan:
- STEP cnt=3, HI=LO=2 → 3 `clk_cpu` pulses, each 2 high/2 low; `done` at clk 14 after accept; cause 1; `cyc_total`=3.
- STEP cnt=0 → no `clk_cpu` edge; `done` 2 cycles after accept; cause 1; `cyc_total` unchanged.
- RUN_BP bp=0x0000_0010, CPU model npc=pc+4 from 0 with `pc_chk`=1 → stops after 4 pulses; cause 3.
- RUN, `halt_req` raised mid-PH_HI of pulse 5 → pulse 5 completes full width; stop after 5 pulses; cause 2.
- RUN_BP where bp match and `halt_req` coincide on the same last PH_LO → cause 3.
- `rstn` low during PH_HI → `clk_cpu`=0 asynchronously, `busy`=0, `cyc_total`=0.
- With SDU_RUN_WDOG_EN and WDOG_CYC=8, RUN → 8 pulses; cause 4.
